instr_encoder_loader: RTL and testbench
=======================================

Name: instr_encoder_loader

Overview:
- Encoder-side counterpart to the instruction decoder: turns symbolic instruction requests into 32-bit Mini-MIPS words and writes them sequentially into instruction memory.
- Used by the testbench/boot path to load programs without a hex file.
- Structure: combinational field encoder, small FIFO, imem write port with ready backpressure, run-control FSM with word counter.

Parameters:
- FIFO_DEPTH, 4, encoded-word FIFO entries; power of 2, ≥2.
- ADDR_W, 32, imem byte-address width.
- CNT_W, 16, width of the program word count.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a load. Honoured only in IDLE or DONE.
- base_addr  in  ADDR_W  byte address of the first word; sampled on start.
- word_count  in  CNT_W  number of words to write; sampled on start.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid && in_ready.
- in_op  in  4  0 add, 1 sub, 2 and, 3 or, 4 xor, 5 not, 6 sll, 7 srl, 8 sra, 9 slt, 10 seq, 11 addi, 12 lw, 13 sw, 14 beq, 15 j.
- in_rs, in_rt, in_rd, in_shamt  in  5 each  register/shift fields.
- in_imm  in  26  imm16 uses bits [15:0]; j target uses [25:0].
- imem_we  out  1  write strobe, equal to FIFO non-empty.
- imem_addr  out  ADDR_W  byte address of the current write.
- imem_wdata  out  32  encoded word at the FIFO head.
- imem_ready  in  1  memory accepts the write when imem_we && imem_ready.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.
- err  out  1  sticky error flag; see Optional Feature.

Behaviour:
- Encoding for ops 0–10 (R-type): {6'b000000, rs, rt, rd, shamt, funct}.
  - funct values: add 100000, sub 100010, and 100100, or 100101, xor 100110, not 100111, sll 000000, srl 000010, sra 000011, slt 101010, seq 101001.
- Encoding for I-type ops: {opcode, rs, rt, imm[15:0]}.
  - Opcodes: addi 001000, lw 100011, sw 101011, beq 000100.
- Encoding for j: {6'b000010, imm[25:0]}.
- FSM states:
  - IDLE: reset state.
  - IDLE or DONE + start: latch base_addr into addr_q, word_count into remaining_acc and remaining_wr; go to RUN. If word_count==0, go to DONE instead.
  - RUN: stay until remaining_wr reaches 0, then go to DONE on the edge of the final write.
  - DONE: stays until the next start.
  - start while in RUN: ignored.
- in_ready = (state==RUN) && !fifo_full && (remaining_acc != 0).
  - Full FIFO blocks a push even if a pop occurs in the same cycle.
- Accept: the encoded word is pushed at the accepting edge and remaining_acc decrements.
  - imem_we rises in the cycle after the edge; latency is 1 cycle when the FIFO was empty.
- Write:
  - On an edge with imem_we && imem_ready: pop the FIFO, addr_q += 4 (wraps modulo 2^ADDR_W), remaining_wr decrements.
  - imem_addr = addr_q.
  - imem_we low → no pop.
  - Peak throughput: one push and one pop per cycle.
- Simultaneous push and pop on a non-full, non-empty FIFO: occupancy unchanged.
- Reset values: state IDLE, FIFO empty, addr_q = 0, counters = 0, err = 0. All outputs are therefore 0 (in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, busy=0, done=0).
- Reset mid-load: queued words are discarded, no further writes, return to IDLE.

Optional Feature:
- Macro: ENC_CHECK_EN.
- Defined:
  - A request with op 0–5 or 9–10 and in_shamt≠0 is illegal.
  - A request with op 6–8 and in_rs≠0 is illegal.
  - An illegal request is accepted (handshake completes) but not pushed, and no counter changes.
  - err is set and stays high until rst or the next honoured start.
- Undefined: fields are encoded as given and err is tied to 0.

Test Plan:
- Reset, then start with base_addr=0x100, word_count=1, then request addi rs=1 rt=2 imm=0x0005 → one write of imem_wdata=0x20220005 at imem_addr=0x100; done=1 one cycle after the write edge.
- word_count=3: add rs=1 rt=2 rd=3, sll rt=4 rd=5 shamt=2, j imm=0x0000040, with imem_ready=1 → writes 0x00221820 @base, 0x00042880 @base+4, 0x08000040 @base+8; a 4th request sees in_ready=0.
- imem_ready held 0, 6 requests offered with FIFO_DEPTH=4 → in_ready drops after 4 accepts and imem_addr holds. Releasing ready drains the words in order with consecutive addresses.
- base_addr=0xFFFFFFFC, 2 words → second write at 0x00000000; start pulsed during RUN has no effect; word_count=0 → done in the next cycle with no imem_we.
- rst asserted with 2 words queued → next cycle imem_we=0, busy=0, done=0; a following start works normally.
- ENC_CHECK_EN defined: add with shamt=3 → accepted, err=1, no write, counters unchanged; the next legal word is written at the unchanged address.

Source files
------------

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: encodes symbolic Mini-MIPS instruction requests into
// 32-bit words, queues them in a small FIFO and writes them sequentially into
// instruction memory under control of a start/run/done FSM.
// Optional build macro: ENC_CHECK_EN enables illegal-field detection and the
// sticky err flag; without it every request is encoded as given and err is 0.
module instr_encoder_loader #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 32,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [25:0]       in_imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  input  logic              imem_ready,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t state, state_next;

  logic [31:0]       enc_word;
  logic              illegal;
  logic [31:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    fifo_cnt;
  logic              fifo_full;
  logic              fifo_empty;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  remaining_acc;
  logic [CNT_W-1:0]  remaining_wr;
  logic              start_ok;
  logic              accept;
  logic              push;
  logic              pop;

  function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] sh,
                                         input logic [5:0] funct);
    return {6'b000000, rs, rt, rd, sh, funct};
  endfunction

  // Field encoder: maps the op code and fields onto the 32-bit instruction word
  always_comb begin
    enc_word = 32'h0;
    case (in_op)
      4'd0:  enc_word = r_type(in_rs, in_rt, in_rd, in_shamt, 6'b100000);
      4'd1:  enc_word = r_type(in_rs, in_rt, in_rd, in_shamt, 6'b100010);
      4'd2:  enc_word = r_type(in_rs, in_rt, in_rd, in_shamt, 6'b100100);
      4'd3:  enc_word = r_type(in_rs, in_rt, in_rd, in_shamt, 6'b100101);
      4'd4:  enc_word = r_type(in_rs, in_rt, in_rd, in_shamt, 6'b100110);
      4'd5:  enc_word = r_type(in_rs, in_rt, in_rd, in_shamt, 6'b100111);
      4'd6:  enc_word = r_type(in_rs, in_rt, in_rd, in_shamt, 6'b000000);
      4'd7:  enc_word = r_type(in_rs, in_rt, in_rd, in_shamt, 6'b000010);
      4'd8:  enc_word = r_type(in_rs, in_rt, in_rd, in_shamt, 6'b000011);
      4'd9:  enc_word = r_type(in_rs, in_rt, in_rd, in_shamt, 6'b101010);
      4'd10: enc_word = r_type(in_rs, in_rt, in_rd, in_shamt, 6'b101001);
      4'd11: enc_word = {6'b001000, in_rs, in_rt, in_imm[15:0]};
      4'd12: enc_word = {6'b100011, in_rs, in_rt, in_imm[15:0]};
      4'd13: enc_word = {6'b101011, in_rs, in_rt, in_imm[15:0]};
      4'd14: enc_word = {6'b000100, in_rs, in_rt, in_imm[15:0]};
      default: enc_word = {6'b000010, in_imm[25:0]};
    endcase
  end

`ifdef ENC_CHECK_EN
  // Field legality: non-shift R-types must not carry a shift amount, shifts must not use rs
  always_comb begin
    illegal = 1'b0;
    if ((in_op <= 4'd5) || (in_op == 4'd9) || (in_op == 4'd10))
      illegal = (in_shamt != 5'd0);
    else if ((in_op >= 4'd6) && (in_op <= 4'd8))
      illegal = (in_rs != 5'd0);
  end
`else
  assign illegal = 1'b0;
`endif

  assign fifo_full  = (fifo_cnt == FULL_CNT);
  assign fifo_empty = (fifo_cnt == '0);
  assign start_ok   = start && ((state == S_IDLE) || (state == S_DONE));
  assign in_ready   = (state == S_RUN) && !fifo_full && (remaining_acc != '0);
  assign accept     = in_valid && in_ready;
  assign push       = accept && !illegal;
  assign imem_we    = !fifo_empty;
  assign pop        = imem_we && imem_ready;
  assign imem_addr  = addr_q;
  assign imem_wdata = fifo_empty ? 32'h0 : fifo_mem[rd_ptr];
  assign busy       = (state == S_RUN);
  assign done       = (state == S_DONE);

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state logic: start is only honoured outside RUN; RUN ends on the final write
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) state_next = (word_count == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        if (pop && (remaining_wr == CNT_W'(1))) state_next = S_DONE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // FIFO storage: data is not reset, the pointers define what is valid
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= enc_word;
  end

  // FIFO pointers and occupancy; a reset drops everything still queued
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + (PTR_W+1)'(1);
        2'b01:   fifo_cnt <= fifo_cnt - (PTR_W+1)'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Write address and the two word counters (accepted vs. written)
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q        <= '0;
      remaining_acc <= '0;
      remaining_wr  <= '0;
    end else if (start_ok) begin
      addr_q        <= base_addr;
      remaining_acc <= word_count;
      remaining_wr  <= word_count;
    end else begin
      if (push) remaining_acc <= remaining_acc - CNT_W'(1);
      if (pop) begin
        addr_q       <= addr_q + ADDR_W'(4);
        remaining_wr <= remaining_wr - CNT_W'(1);
      end
    end
  end

`ifdef ENC_CHECK_EN
  // Sticky error flag, cleared by reset or by the next honoured start
  always_ff @(posedge clk) begin
    if (rst)                    err <= 1'b0;
    else if (start_ok)          err <= 1'b0;
    else if (accept && illegal) err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed testbench for instr_encoder_loader. Define ENC_CHECK_EN for both
// the bench and the design to also exercise the illegal-field checks.
module tb_instr_encoder_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] base_addr;
  logic [15:0] word_count;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
  logic [25:0] in_imm;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        imem_ready;
  logic        busy, done, err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] wr_addr_q [$];
  logic [31:0] wr_data_q [$];

  instr_encoder_loader #(.FIFO_DEPTH(4), .ADDR_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .word_count(word_count), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_shamt(in_shamt), .in_imm(in_imm), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .imem_ready(imem_ready),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Record every completed memory write seen at a rising edge
  always @(posedge clk) begin
    if (imem_we && imem_ready) begin
      wr_addr_q.push_back(imem_addr);
      wr_data_q.push_back(imem_wdata);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [31:0] b, input logic [15:0] c);
    start = 1'b1; base_addr = b; word_count = c;
    tick();
    start = 1'b0;
  endtask

  task automatic set_req(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [4:0] sh, input logic [25:0] imm);
    in_op = op; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh; in_imm = imm;
    in_valid = 1'b1;
  endtask

  // Present one request and hold it until it is accepted (bounded)
  task automatic offer(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [4:0] sh, input logic [25:0] imm);
    int t = 0;
    set_req(op, rs, rt, rd, sh, imm);
    while (!in_ready && t < 50) begin tick(); t++; end
    if (!in_ready) begin
      n_checks++; n_fail++;
      $display("[TB] FAIL offer_timeout: in_ready=%0b required 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (!done && t < 50) begin tick(); t++; end
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL wait_done: done=%0b required 1", done);
    end
  endtask

  task automatic check_writes(input string name, input logic [31:0] ea [], input logic [31:0] ed []);
    n_checks++;
    if (wr_addr_q.size() != ea.size()) begin
      n_fail++;
      $display("[TB] FAIL %s_count: got %0d writes required %0d", name, wr_addr_q.size(), ea.size());
    end else begin
      for (int i = 0; i < ea.size(); i++) begin
        n_checks++;
        if (wr_addr_q[i] !== ea[i] || wr_data_q[i] !== ed[i]) begin
          n_fail++;
          $display("[TB] FAIL %s_%0d: got %h@%h required %h@%h", name, i,
                   wr_data_q[i], wr_addr_q[i], ed[i], ea[i]);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    n_checks++;
    if ({in_ready, imem_we, busy, done, err} !== 5'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_flags: ready,we,busy,done,err=%b required 00000",
               {in_ready, imem_we, busy, done, err});
    end
    n_checks++;
    if (imem_addr !== 32'h0 || imem_wdata !== 32'h0) begin
      n_fail++;
      $display("[TB] FAIL reset_bus: addr=%h wdata=%h required 0/0", imem_addr, imem_wdata);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    wr_addr_q.delete(); wr_data_q.delete();
    do_start(32'h100, 16'd1);
    n_checks++;
    if (busy !== 1'b1 || in_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL single_run: busy=%0b in_ready=%0b required 1/1", busy, in_ready);
    end
    offer(4'd11, 5'd1, 5'd2, 5'd0, 5'd0, 26'h0005);
    n_checks++;
    if (imem_we !== 1'b1 || imem_addr !== 32'h100 || imem_wdata !== 32'h20220005) begin
      n_fail++;
      $display("[TB] FAIL single_write: we=%0b addr=%h wdata=%h required 1 00000100 20220005",
               imem_we, imem_addr, imem_wdata);
    end
    tick();
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0 || imem_we !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL single_done: done=%0b busy=%0b we=%0b required 1/0/0", done, busy, imem_we);
    end
    check_writes("single", '{32'h100}, '{32'h20220005});
  endtask

  task automatic test_back_to_back();
    wr_addr_q.delete(); wr_data_q.delete();
    do_start(32'h200, 16'd3);
    offer(4'd0, 5'd1, 5'd2, 5'd3, 5'd0, 26'h0);
    offer(4'd6, 5'd0, 5'd4, 5'd5, 5'd2, 26'h0);
    offer(4'd15, 5'd0, 5'd0, 5'd0, 5'd0, 26'h0000040);
    set_req(4'd0, 5'd1, 5'd1, 5'd1, 5'd0, 26'h0);
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL b2b_fourth_ready: in_ready=%0b required 0", in_ready);
    end
    in_valid = 1'b0;
    wait_done();
    check_writes("b2b", '{32'h200, 32'h204, 32'h208},
                 '{32'h00221820, 32'h00042880, 32'h08000040});
  endtask

  task automatic test_encodings();
    wr_addr_q.delete(); wr_data_q.delete();
    do_start(32'h400, 16'd8);
    offer(4'd1,  5'd4,  5'd5,  5'd6,  5'd0,  26'h0);
    offer(4'd8,  5'd0,  5'd7,  5'd8,  5'd31, 26'h0);
    offer(4'd12, 5'd29, 5'd8,  5'd0,  5'd0,  26'h000FFFC);
    offer(4'd13, 5'd29, 5'd9,  5'd0,  5'd0,  26'h0000010);
    offer(4'd14, 5'd1,  5'd2,  5'd0,  5'd0,  26'h000FFFF);
    offer(4'd9,  5'd10, 5'd11, 5'd12, 5'd0,  26'h0);
    offer(4'd15, 5'd0,  5'd0,  5'd0,  5'd0,  26'h3FFFFFF);
    offer(4'd7,  5'd0,  5'd1,  5'd2,  5'd4,  26'h3FF0000);
    wait_done();
    check_writes("enc",
      '{32'h400, 32'h404, 32'h408, 32'h40C, 32'h410, 32'h414, 32'h418, 32'h41C},
      '{32'h00853022, 32'h000747C3, 32'h8FA8FFFC, 32'hAFA90010,
        32'h1022FFFF, 32'h014B602A, 32'h0BFFFFFF, 32'h00011102});
  endtask

  task automatic test_backpressure();
    int k = 0;
    wr_addr_q.delete(); wr_data_q.delete();
    imem_ready = 1'b0;
    do_start(32'h300, 16'd6);
    for (int c = 0; c < 6; c++) begin
      set_req(4'd11, 5'd1, 5'd2, 5'd0, 5'd0, 26'(k));
      if (in_ready) k++;
      tick();
    end
    in_valid = 1'b0;
    n_checks++;
    if (k != 4 || in_ready !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL bp_full: accepted=%0d in_ready=%0b required 4/0", k, in_ready);
    end
    n_checks++;
    if (imem_we !== 1'b1 || imem_addr !== 32'h300 || imem_wdata !== 32'h20220000 ||
        wr_addr_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL bp_hold: we=%0b addr=%h wdata=%h writes=%0d required 1 00000300 20220000 0",
               imem_we, imem_addr, imem_wdata, wr_addr_q.size());
    end
    imem_ready = 1'b1;
    for (int i = 4; i < 6; i++) offer(4'd11, 5'd1, 5'd2, 5'd0, 5'd0, 26'(i));
    wait_done();
    check_writes("bp",
      '{32'h300, 32'h304, 32'h308, 32'h30C, 32'h310, 32'h314},
      '{32'h20220000, 32'h20220001, 32'h20220002, 32'h20220003, 32'h20220004, 32'h20220005});
  endtask

  task automatic test_wrap_and_ignored_start();
    wr_addr_q.delete(); wr_data_q.delete();
    do_start(32'hFFFFFFFC, 16'd2);
    offer(4'd2, 5'd1, 5'd2, 5'd3, 5'd0, 26'h0);
    do_start(32'h500, 16'd9);
    n_checks++;
    if (busy !== 1'b1 || imem_addr !== 32'h00000000) begin
      n_fail++;
      $display("[TB] FAIL wrap_ignored_start: busy=%0b addr=%h required 1 00000000", busy, imem_addr);
    end
    offer(4'd3, 5'd4, 5'd5, 5'd6, 5'd0, 26'h0);
    wait_done();
    check_writes("wrap", '{32'hFFFFFFFC, 32'h00000000}, '{32'h00221824, 32'h00853025});
  endtask

  task automatic test_zero_count();
    rst = 1'b1; tick(); rst = 1'b0; tick();
    wr_addr_q.delete(); wr_data_q.delete();
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL zero_pre: done=%0b required 0", done);
    end
    do_start(32'h900, 16'd0);
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0 || imem_we !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL zero_done: done=%0b busy=%0b we=%0b required 1/0/0", done, busy, imem_we);
    end
    tick(); tick();
    check_writes("zero", '{}, '{});
  endtask

  task automatic test_reset_mid_load();
    imem_ready = 1'b0;
    do_start(32'h600, 16'd4);
    offer(4'd0, 5'd1, 5'd2, 5'd3, 5'd0, 26'h0);
    offer(4'd0, 5'd4, 5'd5, 5'd6, 5'd0, 26'h0);
    n_checks++;
    if (imem_we !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL rstmid_queued: we=%0b required 1", imem_we);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if ({imem_we, busy, done, in_ready} !== 4'b0 || imem_addr !== 32'h0) begin
      n_fail++;
      $display("[TB] FAIL rstmid_cleared: we,busy,done,ready=%b addr=%h required 0000 00000000",
               {imem_we, busy, done, in_ready}, imem_addr);
    end
    imem_ready = 1'b1;
    tick();
    wr_addr_q.delete(); wr_data_q.delete();
    do_start(32'h700, 16'd1);
    offer(4'd4, 5'd3, 5'd4, 5'd5, 5'd0, 26'h0);
    wait_done();
    check_writes("rstmid", '{32'h700}, '{32'h00642826});
  endtask

`ifdef ENC_CHECK_EN
  task automatic test_check();
    wr_addr_q.delete(); wr_data_q.delete();
    do_start(32'h800, 16'd1);
    offer(4'd0, 5'd1, 5'd2, 5'd3, 5'd3, 26'h0);
    n_checks++;
    if (err !== 1'b1 || imem_we !== 1'b0 || in_ready !== 1'b1 || imem_addr !== 32'h800) begin
      n_fail++;
      $display("[TB] FAIL chk_illegal: err=%0b we=%0b ready=%0b addr=%h required 1 0 1 00000800",
               err, imem_we, in_ready, imem_addr);
    end
    offer(4'd0, 5'd1, 5'd2, 5'd3, 5'd0, 26'h0);
    wait_done();
    check_writes("chk", '{32'h800}, '{32'h00221820});
    n_checks++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL chk_sticky: err=%0b required 1", err);
    end
    do_start(32'h0, 16'd0);
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL chk_clear: err=%0b required 0", err);
    end
  endtask
`endif

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0; word_count = '0;
    in_valid = 1'b0; in_op = '0; in_rs = '0; in_rt = '0; in_rd = '0;
    in_shamt = '0; in_imm = '0; imem_ready = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_encodings();
    test_backpressure();
    test_wrap_and_ignored_start();
    test_zero_count();
    test_reset_mid_load();
`ifdef ENC_CHECK_EN
    test_check();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
